// File: rtl/overlay_track_ctrl.sv
// overlay_track_ctrl
// Frame-synchronous bridge between the red-centroid calculator and the crosshair
// overlay. Captures the last centroid result of each frame, debounces detection
// with acquire/coast hysteresis and publishes x/y/valid only at frame boundaries.
module overlay_track_ctrl #(
    parameter int IMG_WIDTH    = 640,
    parameter int IMG_HEIGHT   = 480,
    parameter int ACQ_FRAMES   = 3,
    parameter int COAST_FRAMES = 4,
    parameter int SMOOTH       = 1,
    parameter int CNT_W        = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic       i_result_valid,
    input  logic [9:0] i_centroid_x,
    input  logic [8:0] i_centroid_y,
    input  logic       i_object_valid,
    input  logic       i_end_frame,
    output logic [9:0] o_centroid_x,
    output logic [8:0] o_centroid_y,
    output logic       o_red_object_valid,
    output logic       o_commit,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEARCH  = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_TRACK   = 3'd3,
        ST_COAST   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Pending result of the frame currently in flight
    logic [9:0]       pend_x_q;
    logic [8:0]       pend_y_q;
    logic             pend_obj_q;
    logic             pend_flag_q;

    // Committed state and outputs
    state_t           state_q, state_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [9:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic             valid_q;
    logic             commit_q;

    // Frame evaluation inputs: a result arriving with end-of-frame belongs to the closing frame
    logic [9:0]       eval_x;
    logic [8:0]       eval_y;
    logic             eval_obj;
    logic             eval_present;
    logic             hit;

    // Smoothed coordinates, one extra bit so the sum never overflows
    logic [10:0]      sum_x;
    logic [9:0]       sum_y;
    logic [9:0]       upd_x;
    logic [8:0]       upd_y;

    // Saturating counter increments
    logic [CNT_W-1:0] hit_inc;
    logic [CNT_W-1:0] miss_inc;
    logic             acq_reached;
    logic             coast_reached;

    assign eval_x       = i_result_valid ? i_centroid_x   : pend_x_q;
    assign eval_y       = i_result_valid ? i_centroid_y   : pend_y_q;
    assign eval_obj     = i_result_valid ? i_object_valid : pend_obj_q;
    assign eval_present = i_result_valid | pend_flag_q;

    assign hit = eval_present && eval_obj &&
                 (int'(eval_x) < IMG_WIDTH) && (int'(eval_y) < IMG_HEIGHT);

    assign sum_x = {1'b0, x_q} + {1'b0, eval_x} + 11'd1;
    assign sum_y = {1'b0, y_q} + {1'b0, eval_y} + 10'd1;
    assign upd_x = (SMOOTH != 0) ? sum_x[10:1] : eval_x;
    assign upd_y = (SMOOTH != 0) ? sum_y[9:1]  : eval_y;

    assign hit_inc       = (hit_cnt_q  == CNT_MAX) ? hit_cnt_q  : hit_cnt_q  + CNT_ONE;
    assign miss_inc      = (miss_cnt_q == CNT_MAX) ? miss_cnt_q : miss_cnt_q + CNT_ONE;
    assign acq_reached   = (int'(hit_inc)  >= ACQ_FRAMES);
    assign coast_reached = (int'(miss_inc) >= COAST_FRAMES);

    // Capture the latest result of the frame; end-of-frame consumes it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            pend_obj_q  <= 1'b0;
            pend_flag_q <= 1'b0;
        end else if (i_end_frame) begin
            pend_flag_q <= 1'b0;
        end else if (i_result_valid) begin
            pend_x_q    <= i_centroid_x;
            pend_y_q    <= i_centroid_y;
            pend_obj_q  <= i_object_valid;
            pend_flag_q <= 1'b1;
        end
    end

    // Next-state decision applied only when a frame closes
    always_comb begin
        state_d    = state_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        if (!i_enable) begin
            state_d    = ST_IDLE;
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_SEARCH;
                    hit_cnt_d  = '0;
                    miss_cnt_d = '0;
                end
                ST_SEARCH: begin
                    miss_cnt_d = '0;
                    if (hit) begin
                        hit_cnt_d = CNT_ONE;
                        if (ACQ_FRAMES <= 1) begin
                            state_d = ST_TRACK;
                            x_d     = eval_x;
                            y_d     = eval_y;
                        end else begin
                            state_d = ST_ACQUIRE;
                        end
                    end else begin
                        hit_cnt_d = '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (hit) begin
                        hit_cnt_d = hit_inc;
                        if (acq_reached) begin
                            state_d = ST_TRACK;
                            x_d     = eval_x;
                            y_d     = eval_y;
                        end
                    end else begin
                        state_d   = ST_SEARCH;
                        hit_cnt_d = '0;
                    end
                end
                ST_TRACK: begin
                    if (hit) begin
                        miss_cnt_d = '0;
                        x_d        = upd_x;
                        y_d        = upd_y;
                    end else if (COAST_FRAMES <= 1) begin
                        state_d    = ST_SEARCH;
                        hit_cnt_d  = '0;
                        miss_cnt_d = '0;
                    end else begin
                        state_d    = ST_COAST;
                        miss_cnt_d = CNT_ONE;
                    end
                end
                ST_COAST: begin
                    if (hit) begin
                        state_d    = ST_TRACK;
                        miss_cnt_d = '0;
                        x_d        = upd_x;
                        y_d        = upd_y;
                    end else if (coast_reached) begin
                        state_d    = ST_SEARCH;
                        hit_cnt_d  = '0;
                        miss_cnt_d = '0;
                    end else begin
                        miss_cnt_d = miss_inc;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    hit_cnt_d  = '0;
                    miss_cnt_d = '0;
                end
            endcase
        end
    end

    // Register state and overlay outputs at frame boundaries only
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            valid_q    <= 1'b0;
            commit_q   <= 1'b0;
        end else begin
            commit_q <= i_end_frame;
            if (i_end_frame) begin
                state_q    <= state_d;
                hit_cnt_q  <= hit_cnt_d;
                miss_cnt_q <= miss_cnt_d;
                x_q        <= x_d;
                y_q        <= y_d;
                valid_q    <= (state_d == ST_TRACK) || (state_d == ST_COAST);
            end
        end
    end

    assign o_centroid_x       = x_q;
    assign o_centroid_y       = y_q;
    assign o_red_object_valid = valid_q;
    assign o_commit           = commit_q;
    assign o_state            = state_q;

endmodule
